capture_uart_tx: RTL and testbench
==================================

# capture_uart_tx

Readout stage that drains the single-port capture RAM after a 180-point capture window closes and streams its contents out over a UART TX line. It sits directly downstream of the one_turn/Samp_en capture timer. It consumes that block's RAM read port and its capture-complete pulse, and drives the board-level serial output. One frame is sent per start pulse: a fixed header, all stored words MSB-first, then an 8-bit checksum.

## Interface
- BAUD_DIV, 1736: Clk cycles per UART bit (200 MHz / 115200).
- NUM_WORDS, 180: words read from RAM per frame (addresses 0..NUM_WORDS-1).
- ADDR_W, 8: RAM address width; must satisfy 2^ADDR_W ≥ NUM_WORDS.
- RD_LAT, 2: RAM read latency in Clk cycles (address and q both registered).
- HDR0 / HDR1, 8'hA5 / 8'h5A: header bytes.
- Clk  in  1  system clock, 200 MHz.
- Rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle capture-complete pulse; ignored unless idle.
- rd_en  out  1  high while the block owns the RAM address port (upstream mux select).
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  16  RAM q, valid RD_LAT cycles after rd_addr.
- txd  out  1  UART serial data, 8N1, LSB first, idle high.
- busy  out  1  high from start acceptance until the checksum stop bit ends.
- done  out  1  one-cycle pulse after the last stop bit.

## Operation
- Reset values: txd=1, busy=0, done=0, rd_en=0, rd_addr=0, checksum=0, FSM=IDLE.
- Frame format: HDR0, HDR1, then for i=0..NUM_WORDS-1 word[i][15:8], word[i][7:0], then CHK. Total 2+2·NUM_WORDS+1 bytes (363 by default).
- CHK = 8-bit modulo-256 sum of all data bytes; headers are excluded.
- FSM states:
  - IDLE: on start, go to SEND_H0, set busy and clear checksum.
  - SEND_H0 → SEND_H1.
  - SEND_H1 → RD_REQ.
  - RD_REQ: assert rd_en, drive rd_addr=i, go to RD_WAIT.
  - RD_WAIT: wait RD_LAT cycles, latch rd_data into a word register, go to SEND_HI.
  - SEND_HI → SEND_LO.
  - SEND_LO: if i==NUM_WORDS-1 go to SEND_CHK; else increment i and go to RD_REQ.
  - SEND_CHK → FIN.
  - FIN: pulse done, clear busy, go to IDLE.
- Each SEND_* state issues one byte to the serialiser and waits for its completion before advancing.
- The checksum accumulates each data byte as it is issued.
- rd_en stays high from the first RD_REQ until FIN. rd_addr holds its value between reads.
- start while busy is dropped, not queued.
- Reset mid-frame: txd returns high immediately (async), all state returns to reset values, and the partial frame is abandoned.
- rd_addr wraps only through the explicit reset to 0 at FIN. No out-of-range address (≥ NUM_WORDS) is ever driven.

## Timing
- start sampled at edge k: busy=1 after edge k; txd falls (start bit) after edge k+2.
- Each bit is exactly BAUD_DIV cycles. A byte is 10·BAUD_DIV cycles: start 0, d0..d7, stop 1.
- Header bytes and CHK follow the previous stop bit with ≤1 idle cycle. Word hi bytes may follow after ≤ RD_LAT+3 idle cycles (txd held high).
- done pulses 1 cycle after the CHK stop bit completes; busy falls on the same edge.
- Serialiser bit counter: ceil(log2 BAUD_DIV) bits; it reloads on each bit boundary.

## Structure
- Shared package (capture_pkg): NUM_WORDS, ADDR_W, HDR0/HDR1, BAUD_DIV default, and the FSM state encoding. These are shared with the capture timer so the RAM depth and readout length cannot diverge.
- Sub-module uart_byte_tx:
  - ports Clk, Rst_n, tx_start, tx_data[7:0], tx_busy, tx_done, txd;
  - owns the baud counter and shift register, and is reusable for the later SPI/UART debug path.
- Top level holds the FSM, address counter, word register and checksum.

## Test plan
- Reset: assert Rst_n=0 with BAUD_DIV=4 → txd=1, busy=0, done=0, rd_en=0, rd_addr=0; start held low keeps all unchanged for 1000 cycles.
- Bit timing: BAUD_DIV=4, NUM_WORDS=1, start at edge k → txd low from k+2 for 4 cycles. First byte bits are 1,0,1,0,0,1,0,1 (0xA5 LSB first), each 4 cycles, then stop bit high.
- Full frame: default parameters with RAM model word[i]=i, RD_LAT=2 → 363 bytes decoded: A5 5A, then (00, i) for i=0..179, then CHK=0xEE. Exactly one done pulse; rd_addr covers 0..179 once each.
- Minimal frame: NUM_WORDS=1, word[0]=16'h12F0 → bytes A5 5A 12 F0 02; busy high for the whole frame.
- Busy collision: second start pulse mid-frame → ignored; frame identical to the single-start case; one done pulse.
- Reset mid-frame: Rst_n low during byte 50 → txd=1 and busy=0 within the reset; a new start afterwards yields a complete frame beginning A5 5A with rd_addr starting at 0.

Source files
------------

// File: rtl/capture_pkg.sv
// Constants and FSM encoding shared by the capture timer and its UART readout,
// so RAM depth and readout length come from one place.
package capture_pkg;

    localparam int         CAP_NUM_WORDS = 180;
    localparam int         CAP_ADDR_W    = 8;
    localparam int         CAP_BAUD_DIV  = 1736;
    localparam logic [7:0] CAP_HDR0      = 8'hA5;
    localparam logic [7:0] CAP_HDR1      = 8'h5A;

    typedef enum logic [3:0] {
        IDLE,
        SEND_H0,
        SEND_H1,
        RD_REQ,
        RD_WAIT,
        SEND_HI,
        SEND_LO,
        SEND_CHK,
        FIN
    } readout_state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser, LSB first, idle high. txd is a registered copy of the
// shift register LSB, so the line moves one cycle after a byte is accepted.
module uart_byte_tx
    import capture_pkg::*;
#(
    parameter int BAUD_DIV = CAP_BAUD_DIV
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       txd
);

    localparam int                CNT_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_idx;
    logic [9:0]       shreg;
    logic             active;

    // Stop bits and idle both shift in ones, so shreg is all ones when idle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            shreg    <= '1;
            active   <= 1'b0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            txd      <= 1'b1;
        end else begin
            txd <= shreg[0];
            if (tx_start && !active) begin
                shreg    <= {1'b1, tx_data, 1'b0};
                active   <= 1'b1;
                bit_idx  <= '0;
                baud_cnt <= RELOAD;
            end else if (active) begin
                if (baud_cnt == '0) begin
                    baud_cnt <= RELOAD;
                    shreg    <= {1'b1, shreg[9:1]};
                    if (bit_idx == 4'd9) begin
                        active <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end else begin
                    baud_cnt <= baud_cnt - CNT_W'(1);
                end
            end
        end
    end

    assign tx_busy = active;
    // Flags the final cycle of the stop bit so the next byte can follow closely.
    assign tx_done = active && (bit_idx == 4'd9) && (baud_cnt == '0);

endmodule

// File: rtl/capture_uart_tx.sv
// Drains the capture RAM after a capture window and streams it over UART:
// two header bytes, every word MSB first, then a modulo-256 data checksum.
module capture_uart_tx
    import capture_pkg::*;
#(
    parameter int         BAUD_DIV  = CAP_BAUD_DIV,
    parameter int         NUM_WORDS = CAP_NUM_WORDS,
    parameter int         ADDR_W    = CAP_ADDR_W,
    parameter int         RD_LAT    = 2,
    parameter logic [7:0] HDR0      = CAP_HDR0,
    parameter logic [7:0] HDR1      = CAP_HDR1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam int                 WAIT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);

    readout_state_t    state, state_next;
    logic              issued, issued_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [15:0]       word_q;
    logic [7:0]        checksum;
    logic              tx_start, tx_busy, tx_done, byte_done;
    logic [7:0]        tx_data;

    uart_byte_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .txd      (txd)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= IDLE;
            issued <= 1'b0;
        end else begin
            state  <= state_next;
            issued <= issued_next;
        end
    end

    // Each SEND_* state issues its byte once, then waits for that byte to finish.
    always_comb begin
        state_next  = state;
        issued_next = issued;
        tx_data     = 8'h00;
        tx_start    = 1'b0;
        byte_done   = issued && tx_done;
        if (state inside {SEND_H0, SEND_H1, SEND_HI, SEND_LO, SEND_CHK}) begin
            tx_start = !issued && !tx_busy;
        end
        if (tx_start) begin
            issued_next = 1'b1;
        end
        if (byte_done) begin
            issued_next = 1'b0;
        end
        case (state)
            IDLE:     if (start) state_next = SEND_H0;
            SEND_H0: begin
                tx_data = HDR0;
                if (byte_done) state_next = SEND_H1;
            end
            SEND_H1: begin
                tx_data = HDR1;
                if (byte_done) state_next = RD_REQ;
            end
            RD_REQ:   state_next = RD_WAIT;
            RD_WAIT:  if (wait_cnt == WAIT_LAST) state_next = SEND_HI;
            SEND_HI: begin
                tx_data = word_q[15:8];
                if (byte_done) state_next = SEND_LO;
            end
            SEND_LO: begin
                tx_data = word_q[7:0];
                if (byte_done) state_next = (rd_addr == ADDR_LAST) ? SEND_CHK : RD_REQ;
            end
            SEND_CHK: begin
                tx_data = checksum;
                if (byte_done) state_next = FIN;
            end
            FIN:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // rd_addr doubles as the word index; it only returns to 0 when the frame ends.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            wait_cnt <= '0;
            word_q   <= '0;
            checksum <= '0;
        end else begin
            done <= (state == FIN);
            if (state == IDLE && start) begin
                busy     <= 1'b1;
                checksum <= '0;
            end
            if (state_next == RD_REQ) begin
                rd_en <= 1'b1;
            end
            if (state == RD_WAIT) begin
                if (wait_cnt == WAIT_LAST) begin
                    word_q   <= rd_data;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end
            if (tx_start && (state == SEND_HI || state == SEND_LO)) begin
                checksum <= checksum + tx_data;
            end
            if (state == SEND_LO && byte_done && rd_addr != ADDR_LAST) begin
                rd_addr <= rd_addr + ADDR_W'(1);
            end
            if (state == FIN) begin
                busy    <= 1'b0;
                rd_en   <= 1'b0;
                rd_addr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_capture_uart_tx.sv
// Bench for capture_uart_tx: a 180-word instance (a) and a 1-word instance (b),
// both at 4 clocks per bit, each with a two-stage registered RAM model.
module tb_capture_uart_tx;
    import capture_pkg::*;

    localparam int BAUD = 4;
    localparam int NW_A = CAP_NUM_WORDS;
    localparam int NW_B = 1;
    localparam int AW   = CAP_ADDR_W;

    typedef struct {
        logic  start;
        logic  exp_txd;
        logic  exp_busy;
        logic  exp_done;
        int    hold;
        string tag;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a_n, rst_b_n, start_a, start_b;
    logic          rd_en_a, rd_en_b, txd_a, txd_b, busy_a, busy_b, done_a, done_b;
    logic [AW-1:0] rd_addr_a, rd_addr_b, ram_addr_a, ram_addr_b;
    logic [15:0]   rd_data_a, rd_data_b;

    int errors = 0;
    int checks = 0;

    logic [7:0]    rx_a[$];
    logic [7:0]    rx_b[$];
    logic [AW-1:0] addr_seq[$];
    logic          prev_en_a = 1'b0;
    logic [AW-1:0] prev_addr_a = '0;
    int            oor_cnt = 0;

    capture_uart_tx #(.BAUD_DIV(BAUD), .NUM_WORDS(NW_A), .ADDR_W(AW), .RD_LAT(2),
                      .HDR0(8'hA5), .HDR1(8'h5A)) dut_a (
        .Clk(clk), .Rst_n(rst_a_n), .start(start_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .rd_data(rd_data_a), .txd(txd_a), .busy(busy_a), .done(done_a));

    capture_uart_tx #(.BAUD_DIV(BAUD), .NUM_WORDS(NW_B), .ADDR_W(AW), .RD_LAT(2),
                      .HDR0(8'hA5), .HDR1(8'h5A)) dut_b (
        .Clk(clk), .Rst_n(rst_b_n), .start(start_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .txd(txd_b), .busy(busy_b), .done(done_b));

    // RAM models: address and q both registered, word[i] = i for a, 16'h12F0 for b.
    always @(posedge clk) begin
        ram_addr_a <= rd_addr_a;
        rd_data_a  <= {8'h00, ram_addr_a};
        ram_addr_b <= rd_addr_b;
        rd_data_b  <= (ram_addr_b == '0) ? 16'h12F0 : 16'hDEAD;
    end

    always @(negedge clk) begin
        if (rd_en_a === 1'b1 && (!prev_en_a || rd_addr_a != prev_addr_a)) addr_seq.push_back(rd_addr_a);
        if (int'(rd_addr_a) >= NW_A || int'(rd_addr_b) >= NW_B) oor_cnt <= oor_cnt + 1;
        prev_en_a   <= rd_en_a;
        prev_addr_a <= rd_addr_a;
    end

    function automatic logic lineOf(input int w);
        return (w == 0) ? txd_a : txd_b;
    endfunction

    function automatic logic rstOf(input int w);
        return (w == 0) ? rst_a_n : rst_b_n;
    endfunction

    // Mid-bit sampling; any byte overlapping a reset is discarded.
    task automatic rxByte(input int w, output logic [7:0] b, output logic ok);
        ok = 1'b1;
        b  = '0;
        repeat (BAUD / 2) @(negedge clk);
        if (lineOf(w) !== 1'b0 || rstOf(w) !== 1'b1) ok = 1'b0;
        for (int j = 0; j < 8; j++) begin
            repeat (BAUD) @(negedge clk);
            b[j] = lineOf(w);
            if (rstOf(w) !== 1'b1) ok = 1'b0;
        end
        repeat (BAUD) @(negedge clk);
        if (lineOf(w) !== 1'b1 || rstOf(w) !== 1'b1) ok = 1'b0;
    endtask

    always begin : rx_mon_a
        logic [7:0] b;
        logic       ok;
        @(negedge clk);
        if (rst_a_n === 1'b1 && txd_a === 1'b0) begin
            rxByte(0, b, ok);
            if (ok) rx_a.push_back(b);
        end
    end

    always begin : rx_mon_b
        logic [7:0] b;
        logic       ok;
        @(negedge clk);
        if (rst_b_n === 1'b1 && txd_b === 1'b0) begin
            rxByte(1, b, ok);
            if (ok) rx_b.push_back(b);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int w, input logic s);
        if (w == 0) start_a = s;
        else        start_b = s;
        @(negedge clk);
    endtask

    // Runs until done plus a 50-cycle tail; optionally pulses start again at cycle restart_at.
    task automatic waitDone(input int w, input int budget, input int restart_at,
                            output int n_done, output logic busy_ok);
        int seen_at = -1;
        n_done  = 0;
        busy_ok = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (w == 0) start_a = (c == restart_at);
            else        start_b = (c == restart_at);
            @(negedge clk);
            if (((w == 0) ? done_a : done_b) === 1'b1) begin
                n_done++;
                if (seen_at < 0) seen_at = c;
            end
            if (seen_at < 0 && ((w == 0) ? busy_a : busy_b) !== 1'b1) busy_ok = 1'b0;
            if (seen_at >= 0 && c - seen_at >= 50) break;
        end
    endtask

    task automatic compareFrame(input string name, input int w, input int snap, input logic [7:0] exp_q[$]);
        logic [7:0] got[$];
        int n;
        if (w == 0) got = rx_a;
        else        got = rx_b;
        n = got.size() - snap;
        checkOutput({name, " byte count"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            checkOutput($sformatf("%s byte %0d", name, i), got[snap + i], exp_q[i]);
        end
    endtask

    task automatic checkIdle(input string name, input int w);
        if (w == 0) begin
            checkOutput({name, " txd"}, txd_a, 1'b1);
            checkOutput({name, " busy"}, busy_a, 1'b0);
            checkOutput({name, " done"}, done_a, 1'b0);
            checkOutput({name, " rd_en"}, rd_en_a, 1'b0);
            checkOutput({name, " rd_addr"}, rd_addr_a, 0);
        end else begin
            checkOutput({name, " txd"}, txd_b, 1'b1);
            checkOutput({name, " busy"}, busy_b, 1'b0);
            checkOutput({name, " done"}, done_b, 1'b0);
            checkOutput({name, " rd_en"}, rd_en_b, 1'b0);
            checkOutput({name, " rd_addr"}, rd_addr_b, 0);
        end
    endtask

    function automatic vec_t mkVec(input logic s, input logic t, input int h, input string tag);
        vec_t v;
        v.start    = s;
        v.exp_txd  = t;
        v.exp_busy = 1'b1;
        v.exp_done = 1'b0;
        v.hold     = h;
        v.tag      = tag;
        return v;
    endfunction

    initial begin
        repeat (100000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       vecs[$];
        logic [7:0] exp_a[$];
        logic [7:0] exp_b[$];
        logic [7:0] hdr;
        int         snap, asnap, n_done, moved_a, moved_b;
        logic       busy_ok;

        // Bit-level expectation for b: accept, load cycle, A5 framed LSB first,
        // one idle cycle, then the start bit of 5A.
        hdr = 8'hA5;
        vecs.push_back(mkVec(1'b1, 1'b1, 1, "accept"));
        vecs.push_back(mkVec(1'b0, 1'b1, 1, "load"));
        vecs.push_back(mkVec(1'b0, 1'b0, BAUD, "H0 start bit"));
        for (int j = 0; j < 8; j++) vecs.push_back(mkVec(1'b0, hdr[j], BAUD, $sformatf("H0 d%0d", j)));
        vecs.push_back(mkVec(1'b0, 1'b1, BAUD, "H0 stop bit"));
        vecs.push_back(mkVec(1'b0, 1'b1, 1, "H0-H1 gap"));
        vecs.push_back(mkVec(1'b0, 1'b0, BAUD, "H1 start bit"));

        exp_b = '{8'hA5, 8'h5A, 8'h12, 8'hF0, 8'h02};
        exp_a.push_back(8'hA5);
        exp_a.push_back(8'h5A);
        for (int i = 0; i < NW_A; i++) begin
            exp_a.push_back(8'h00);
            exp_a.push_back(8'(i));
        end
        exp_a.push_back(8'hEE);

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (5) @(negedge clk);
        checkIdle("reset a", 0);
        checkIdle("reset b", 1);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        moved_a = 0;
        moved_b = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (txd_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || rd_en_a !== 1'b0 || rd_addr_a !== '0) moved_a++;
            if (txd_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0 || rd_en_b !== 1'b0 || rd_addr_b !== '0) moved_b++;
        end
        checkOutput("idle stable a", moved_a, 0);
        checkOutput("idle stable b", moved_b, 0);

        $display("[TB] minimal frame with bit timing on b");
        snap = rx_b.size();
        foreach (vecs[v]) begin
            for (int c = 0; c < vecs[v].hold; c++) begin
                applyStimulus(1, (c == 0) ? vecs[v].start : 1'b0);
                checkOutput({vecs[v].tag, " txd"}, txd_b, vecs[v].exp_txd);
                checkOutput({vecs[v].tag, " busy"}, busy_b, vecs[v].exp_busy);
                checkOutput({vecs[v].tag, " done"}, done_b, vecs[v].exp_done);
            end
        end
        waitDone(1, 2000, -1, n_done, busy_ok);
        checkOutput("minimal done count", n_done, 1);
        checkOutput("minimal busy held", busy_ok, 1'b1);
        checkOutput("minimal busy after", busy_b, 1'b0);
        compareFrame("minimal", 1, snap, exp_b);

        $display("[TB] busy collision on b");
        repeat (60) @(negedge clk);
        snap = rx_b.size();
        applyStimulus(1, 1'b1);
        waitDone(1, 2000, 100, n_done, busy_ok);
        checkOutput("collision done count", n_done, 1);
        checkOutput("collision busy held", busy_ok, 1'b1);
        compareFrame("collision", 1, snap, exp_b);

        $display("[TB] reset during byte 50 on a");
        snap = rx_a.size();
        applyStimulus(0, 1'b1);
        start_a = 1'b0;
        for (int c = 0; c < 5000 && (rx_a.size() - snap) < 49; c++) @(negedge clk);
        checkOutput("bytes before reset", rx_a.size() - snap, 49);
        for (int c = 0; c < 60 && txd_a !== 1'b0; c++) @(negedge clk);
        checkOutput("txd low before reset", txd_a, 1'b0);
        checkOutput("busy before reset", busy_a, 1'b1);
        #1 rst_a_n = 1'b0;
        #1;
        checkIdle("async reset a", 0);
        repeat (10) @(negedge clk);
        checkIdle("held reset a", 0);
        rst_a_n = 1'b1;
        repeat (60) @(negedge clk);

        $display("[TB] full frame on a");
        snap  = rx_a.size();
        asnap = addr_seq.size();
        applyStimulus(0, 1'b1);
        waitDone(0, 25000, -1, n_done, busy_ok);
        checkOutput("full done count", n_done, 1);
        checkOutput("full busy held", busy_ok, 1'b1);
        compareFrame("full", 0, snap, exp_a);
        checkOutput("addr count", addr_seq.size() - asnap, NW_A);
        for (int i = 0; i < NW_A && asnap + i < addr_seq.size(); i++) begin
            checkOutput($sformatf("addr %0d", i), addr_seq[asnap + i], i);
        end
        checkOutput("rd_addr after frame", rd_addr_a, 0);
        checkOutput("rd_en after frame", rd_en_a, 1'b0);
        checkOutput("out-of-range addresses", oor_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
